// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared SPI defaults and scheduler FSM state codes
package spi_sched_pkg;

    localparam int LEN_DATA_DEF = 8;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2,
        ST_FIN  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin pick starting after last_owner
module spi_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0] sum;

    // Scan last_owner+1 .. last_owner+NUM_REQ so the previous owner is checked last.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        sum        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_owner} + (IDX_W+1)'(i);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            if (!any && req[sum[IDX_W-1:0]]) begin
                winner[sum[IDX_W-1:0]] = 1'b1;
                winner_idx             = sum[IDX_W-1:0];
                any                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_sched.sv
// rtl/spi_sched.sv - round-robin scheduler sharing one SPI master between requesters
module spi_sched
    import spi_sched_pkg::*;
#(
    parameter int LEN_DATA  = LEN_DATA_DEF,
    parameter int NUM_REQ   = 2,
    parameter int LEN_BURST = 3,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LEN_BURST-1:0]  req_len,
    input  logic [NUM_REQ*LEN_DATA-1:0]   req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            tx_pop,
    output logic [LEN_DATA-1:0]           rx_data,
    output logic [NUM_REQ-1:0]            rx_valid,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          m_start,
    output logic [LEN_DATA-1:0]           m_tx_data,
    output logic                          m_ss_hold,
    input  logic                          m_done,
    input  logic [LEN_DATA-1:0]           m_rx_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    spi_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [LEN_BURST-1:0] len_q, len_d;
    logic [LEN_BURST-1:0] byte_cnt_q, byte_cnt_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [NUM_REQ-1:0]   tx_pop_q, tx_pop_d;
    logic [NUM_REQ-1:0]   rx_valid_q, rx_valid_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [LEN_DATA-1:0]  rx_data_q, rx_data_d;
    logic [LEN_DATA-1:0]  m_tx_data_q, m_tx_data_d;
    logic                 m_start_q, m_start_d;
    logic                 m_ss_hold_q, m_ss_hold_d;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic [LEN_BURST-1:0] win_len;
    logic [LEN_DATA-1:0]  own_data;
    logic                 last_byte;
    logic                 timeout;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (win_onehot),
        .winner_idx (win_idx),
        .any        (win_any)
    );

    always_comb begin
        win_len  = '0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_len = req_len[i*LEN_BURST +: LEN_BURST];
            end
            if (owner_q == IDX_W'(i)) begin
                own_data = req_data[i*LEN_DATA +: LEN_DATA];
            end
        end
    end

    assign last_byte = (byte_cnt_q == len_q);
    // m_done takes precedence over the watchdog firing in the same cycle.
    assign timeout   = (state_q == ST_XFER) && !m_done && (wdog_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            len_q        <= '0;
            byte_cnt_q   <= '0;
            wdog_q       <= '0;
            tx_pop_q     <= '0;
            rx_valid_q   <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rx_data_q    <= '0;
            m_tx_data_q  <= '0;
            m_start_q    <= 1'b0;
            m_ss_hold_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            wdog_q       <= wdog_d;
            tx_pop_q     <= tx_pop_d;
            rx_valid_q   <= rx_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rx_data_q    <= rx_data_d;
            m_tx_data_q  <= m_tx_data_d;
            m_start_q    <= m_start_d;
            m_ss_hold_q  <= m_ss_hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_any) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_XFER;
            ST_XFER: begin
                if (m_done) begin
                    state_d = last_byte ? ST_FIN : ST_LOAD;
                end else if (timeout) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        wdog_d       = wdog_q;
        rx_data_d    = rx_data_q;
        m_tx_data_d  = m_tx_data_q;
        m_ss_hold_d  = m_ss_hold_q;
        tx_pop_d     = '0;
        rx_valid_d   = '0;
        done_d       = '0;
        err_d        = '0;
        m_start_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    grant_d     = win_onehot;
                    owner_d     = win_idx;
                    len_d       = win_len;
                    byte_cnt_d  = '0;
                    m_ss_hold_d = 1'b1;
                end
            end
            ST_LOAD: begin
                m_start_d   = 1'b1;
                m_tx_data_d = own_data;
                tx_pop_d    = grant_q;
                wdog_d      = '0;
            end
            ST_XFER: begin
                if (m_done) begin
                    rx_data_d  = m_rx_data;
                    rx_valid_d = grant_q;
                    if (last_byte) begin
                        done_d = grant_q;
                    end else begin
                        byte_cnt_d = byte_cnt_q + LEN_BURST'(1);
                    end
                end else if (timeout) begin
                    err_d = grant_q;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_FIN: begin
                m_ss_hold_d  = 1'b0;
                grant_d      = '0;
                last_owner_d = owner_q;
            end
            default: ;
        endcase
    end

    assign grant     = grant_q;
    assign tx_pop    = tx_pop_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_start   = m_start_q;
    assign m_tx_data = m_tx_data_q;
    assign m_ss_hold = m_ss_hold_q;

endmodule

// File: tb/tb_spi_sched.sv
// tb/tb_spi_sched.sv - directed self-checking bench for spi_sched
module tb_spi_sched;

    localparam int LD = 8;
    localparam int NR = 2;
    localparam int LB = 3;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*LB-1:0]  req_len;
    logic [NR*LD-1:0]  req_data;
    logic [NR-1:0]     grant, tx_pop, rx_valid, done, err;
    logic [LD-1:0]     rx_data, m_tx_data, m_rx_data;
    logic              m_start, m_ss_hold, m_done;

    spi_sched #(
        .LEN_DATA  (LD),
        .NUM_REQ   (NR),
        .LEN_BURST (LB),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_len   (req_len),
        .req_data  (req_data),
        .grant     (grant),
        .tx_pop    (tx_pop),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .err       (err),
        .m_start   (m_start),
        .m_tx_data (m_tx_data),
        .m_ss_hold (m_ss_hold),
        .m_done    (m_done),
        .m_rx_data (m_rx_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc, n_start, n_pop0, n_pop1, n_rxv0, n_rxv1, n_done0, n_done1, n_err0, n_err1;
    int ss_rise, ss_fall, rise_cyc, fall_cyc, start_cyc, done_cyc, err_cyc, gap_bad, onehot_bad;
    int pend, resp_delay, sent_cyc;
    bit resp_en, auto_drop, sent_flag;
    logic [LD-1:0] resp_rx, last_tx, last_rx;
    logic prev_ss;
    logic [NR-1:0] prev_grant;
    logic [NR-1:0] grant_log[$];

    task automatic clear_cnt();
        n_start = 0; n_pop0 = 0; n_pop1 = 0; n_rxv0 = 0; n_rxv1 = 0;
        n_done0 = 0; n_done1 = 0; n_err0 = 0; n_err1 = 0;
        ss_rise = 0; ss_fall = 0; rise_cyc = 0; fall_cyc = 0;
        start_cyc = 0; done_cyc = 0; err_cyc = 0; gap_bad = 0; onehot_bad = 0;
        sent_flag = 0; last_tx = '0; last_rx = '0;
        prev_ss = m_ss_hold; prev_grant = grant;
        grant_log.delete();
    endtask

    // One clock: sample outputs 1ns after the edge, then play the SPI master.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_start) begin
            n_start++;
            last_tx   = m_tx_data;
            start_cyc = cyc;
            if (sent_flag) begin
                if (cyc - sent_cyc != 2) gap_bad++;
                sent_flag = 0;
            end
        end
        if (tx_pop[0])   n_pop0++;
        if (tx_pop[1])   n_pop1++;
        if (rx_valid[0]) begin n_rxv0++; last_rx = rx_data; end
        if (rx_valid[1]) begin n_rxv1++; last_rx = rx_data; end
        if (done != 0 || err != 0) sent_flag = 0;
        if (done[0]) begin n_done0++; done_cyc = cyc; end
        if (done[1]) begin n_done1++; done_cyc = cyc; end
        if (err[0])  begin n_err0++;  err_cyc = cyc; end
        if (err[1])  begin n_err1++;  err_cyc = cyc; end
        if (m_ss_hold && !prev_ss) begin ss_rise++; rise_cyc = cyc; end
        if (!m_ss_hold && prev_ss) begin ss_fall++; fall_cyc = cyc; end
        prev_ss = m_ss_hold;
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant);
        if ($countones(grant) > 1) onehot_bad++;
        prev_grant = grant;
        if (auto_drop) req = req & ~grant;
        m_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                m_done    = 1'b1;
                m_rx_data = resp_rx;
                resp_rx   = resp_rx + 8'd1;
                sent_flag = 1;
                sent_cyc  = cyc;
            end
        end
        if (m_start && resp_en) pend = resp_delay;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; m_done = 1'b0; pend = 0;
        step(); step();
        rst_n = 1'b1;
        clear_cnt();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; m_done = 1'b1; pend = 0;
        step(); step();
        checks++;
        if ({grant, tx_pop, rx_valid, done, err} !== '0)
            $display("FAIL reset_pulses got %b want 0", {grant, tx_pop, rx_valid, done, err});
        checks++;
        if ({m_start, m_ss_hold} !== 2'b00)
            $display("FAIL reset_master got start=%b ss=%b want 0 0", m_start, m_ss_hold);
        checks++;
        if ({m_tx_data, rx_data} !== '0)
            $display("FAIL reset_data got tx=%h rx=%h want 00 00", m_tx_data, rx_data);
        errors += ((({grant, tx_pop, rx_valid, done, err} !== '0)) ? 1 : 0)
                + ((({m_start, m_ss_hold} !== 2'b00)) ? 1 : 0)
                + ((({m_tx_data, rx_data} !== '0)) ? 1 : 0);
        m_done = 1'b0; req = '0;
        rst_n = 1'b1;
        clear_cnt();
    endtask

    task automatic test_single();
        do_reset();
        req_len = '0; req_data = {8'h00, 8'hA5};
        resp_en = 1; resp_delay = 10; resp_rx = 8'h3C; auto_drop = 1;
        req = 2'b01;
        repeat (30) step();
        checks++;
        if (n_start != 1 || last_tx !== 8'hA5) begin
            errors++; $display("FAIL single_start got n=%0d tx=%h want 1 a5", n_start, last_tx);
        end
        checks++;
        if (n_pop0 != 1 || n_pop1 != 0) begin
            errors++; $display("FAIL single_pop got %0d/%0d want 1/0", n_pop0, n_pop1);
        end
        checks++;
        if (n_rxv0 != 1 || last_rx !== 8'h3C) begin
            errors++; $display("FAIL single_rx got n=%0d rx=%h want 1 3c", n_rxv0, last_rx);
        end
        checks++;
        if (n_done0 != 1 || done_cyc - start_cyc != 11) begin
            errors++; $display("FAIL single_done got n=%0d lat=%0d want 1 11", n_done0, done_cyc - start_cyc);
        end
        checks++;
        if (ss_rise != 1 || ss_fall != 1 || rise_cyc >= start_cyc || fall_cyc != done_cyc + 1) begin
            errors++; $display("FAIL single_ss got rise=%0d@%0d fall=%0d@%0d want 1 before %0d, 1@%0d",
                               ss_rise, rise_cyc, ss_fall, fall_cyc, start_cyc, done_cyc + 1);
        end
        checks++;
        if (grant_log.size() != 1 || grant_log[0] !== 2'b01) begin
            errors++; $display("FAIL single_grant got count=%0d want one grant 01", grant_log.size());
        end
    endtask

    task automatic test_burst();
        do_reset();
        req_len = {3'd0, 3'd2}; req_data = {8'h00, 8'h11};
        resp_en = 1; resp_delay = 4; resp_rx = 8'h50; auto_drop = 1;
        req = 2'b01;
        for (int i = 0; i < 10 && grant == 0; i++) step();
        req_len = '0;
        repeat (60) step();
        checks++;
        if (n_start != 3 || n_pop0 != 3) begin
            errors++; $display("FAIL burst_start got start=%0d pop=%0d want 3 3", n_start, n_pop0);
        end
        checks++;
        if (n_rxv0 != 3 || last_rx !== 8'h52) begin
            errors++; $display("FAIL burst_rx got n=%0d rx=%h want 3 52", n_rxv0, last_rx);
        end
        checks++;
        if (ss_rise != 1 || ss_fall != 1) begin
            errors++; $display("FAIL burst_ss got rise=%0d fall=%0d want 1 1", ss_rise, ss_fall);
        end
        checks++;
        if (n_done0 != 1 || gap_bad != 0) begin
            errors++; $display("FAIL burst_done got done=%0d gap_bad=%0d want 1 0", n_done0, gap_bad);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_len = '0; req_data = {8'h22, 8'h11};
        resp_en = 1; resp_delay = 3; resp_rx = 8'h00; auto_drop = 0;
        req = 2'b11;
        repeat (40) step();
        req = '0;
        repeat (10) step();
        checks++;
        if (grant_log.size() < 4) begin
            errors++; $display("FAIL rr_count got %0d grants want >=4", grant_log.size());
        end else begin
            checks++;
            if (grant_log[0] !== 2'b01 || grant_log[1] !== 2'b10 ||
                grant_log[2] !== 2'b01 || grant_log[3] !== 2'b10) begin
                errors++; $display("FAIL rr_order got %b %b %b %b want 01 10 01 10",
                                   grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
            end
        end
        checks++;
        if (onehot_bad != 0 || n_done0 < 2 || n_done1 < 2) begin
            errors++; $display("FAIL rr_done got onehot_bad=%0d d0=%0d d1=%0d want 0 >=2 >=2",
                               onehot_bad, n_done0, n_done1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req_len = '0; req_data = {8'h00, 8'h33};
        resp_en = 0; auto_drop = 1;
        req = 2'b01;
        repeat (30) step();
        checks++;
        if (n_err0 != 1 || n_done0 != 0 || n_start != 1) begin
            errors++; $display("FAIL timeout_err got err=%0d done=%0d start=%0d want 1 0 1", n_err0, n_done0, n_start);
        end
        checks++;
        if (err_cyc - start_cyc != TO) begin
            errors++; $display("FAIL timeout_lat got %0d want %0d", err_cyc - start_cyc, TO);
        end
        checks++;
        if (grant !== 2'b00 || m_ss_hold !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got grant=%b ss=%b want 00 0", grant, m_ss_hold);
        end
        // m_done arriving on the watchdog's last cycle must complete normally.
        clear_cnt();
        resp_en = 1; resp_delay = TO - 1; resp_rx = 8'h44;
        req = 2'b10;
        repeat (30) step();
        checks++;
        if (n_done1 != 1 || n_err1 != 0 || n_rxv1 != 1 || last_rx !== 8'h44) begin
            errors++; $display("FAIL timeout_tie got done=%0d err=%0d rxv=%0d rx=%h want 1 0 1 44",
                               n_done1, n_err1, n_rxv1, last_rx);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_len = {3'd0, 3'd2}; req_data = {8'h77, 8'h55};
        resp_en = 1; resp_delay = 5; resp_rx = 8'h60; auto_drop = 1;
        req = 2'b01;
        for (int i = 0; i < 100 && n_start < 2; i++) step();
        repeat (2) step();
        rst_n = 1'b0; pend = 0; m_done = 1'b0;
        step();
        checks++;
        if ({grant, tx_pop, rx_valid, done, err, m_start, m_ss_hold} !== '0 ||
            {m_tx_data, rx_data} !== '0 || n_start != 2) begin
            errors++; $display("FAIL midrst_outputs got ctl=%b tx=%h rx=%h start=%0d want 0 00 00 2",
                               {grant, tx_pop, rx_valid, done, err, m_start, m_ss_hold},
                               m_tx_data, rx_data, n_start);
        end
        checks++;
        if (n_done0 != 0 || n_err0 != 0) begin
            errors++; $display("FAIL midrst_pulse got done=%0d err=%0d want 0 0", n_done0, n_err0);
        end
        rst_n = 1'b1;
        clear_cnt();
        req_len = {3'd1, 3'd0};
        req = 2'b10;
        repeat (40) step();
        checks++;
        if (grant_log.size() != 1 || grant_log[0] !== 2'b10) begin
            errors++; $display("FAIL midrst_grant got count=%0d want one grant 10", grant_log.size());
        end
        checks++;
        if (n_done1 != 1 || n_start != 2 || n_pop1 != 2 || last_tx !== 8'h77 || n_done0 != 0) begin
            errors++; $display("FAIL midrst_next got done1=%0d start=%0d pop1=%0d tx=%h done0=%0d want 1 2 2 77 0",
                               n_done1, n_start, n_pop1, last_tx, n_done0);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        req_len = {3'd0, 3'd1}; req_data = {8'h00, 8'h99};
        resp_en = 1; resp_delay = 3; resp_rx = 8'h70; auto_drop = 1;
        repeat (3) begin
            step();
            m_done = 1'b1; m_rx_data = 8'hEE;
        end
        step();
        checks++;
        if (n_rxv0 + n_rxv1 + n_done0 + n_done1 + n_err0 + n_err1 + n_start != 0 ||
            grant_log.size() != 0 || rx_data !== 8'h00) begin
            errors++; $display("FAIL spur_idle got rxv=%0d start=%0d grants=%0d rx=%h want 0 0 0 00",
                               n_rxv0 + n_rxv1, n_start, grant_log.size(), rx_data);
        end
        req = 2'b01;
        repeat (40) step();
        checks++;
        if (n_done0 != 1 || n_start != 2 || n_rxv0 != 2 || last_rx !== 8'h71) begin
            errors++; $display("FAIL spur_burst got done=%0d start=%0d rxv=%0d rx=%h want 1 2 2 71",
                               n_done0, n_start, n_rxv0, last_rx);
        end
    endtask

    initial begin
        cyc = 0; pend = 0; resp_en = 0; auto_drop = 0; resp_delay = 1; resp_rx = '0;
        rst_n = 1'b0; req = '0; req_len = '0; req_data = '0; m_done = 1'b0; m_rx_data = '0;
        test_reset();
        test_contention();
        test_single();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sched.md
SPI_SCHED -- requirements
Module: spi_sched

Interface
REQ-001 Parameter LEN_DATA, default 8, bits per SPI byte.
REQ-002 Parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-003 Parameter LEN_BURST, default 3, width of per-requester length field; bytes per burst = len+1.
REQ-004 Parameter TIMEOUT, default 255, max clk cycles waited for m_done per byte.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req  in  NUM_REQ  per-requester transaction request, level.
REQ-008 req_len  in  NUM_REQ*LEN_BURST  flattened burst lengths, requester i at slice i.
REQ-009 req_data  in  NUM_REQ*LEN_DATA  flattened next TX byte, requester i at slice i.
REQ-010 grant  out  NUM_REQ  one-hot owner of the SPI master.
REQ-011 tx_pop  out  NUM_REQ  1-cycle pulse: owner's req_data byte consumed.
REQ-012 rx_data  out  LEN_DATA  last received byte; rx_valid  out  NUM_REQ  1-cycle pulse to owner.
REQ-013 done  out  NUM_REQ  1-cycle burst-complete pulse; err  out  NUM_REQ  1-cycle timeout pulse.
REQ-014 m_start  out  1  1-cycle start to SPI master; m_tx_data  out  LEN_DATA  byte to shift out.
REQ-015 m_ss_hold  out  1  high for whole burst, keeps SS asserted between bytes.
REQ-016 m_done  in  1  1-cycle byte-complete pulse from master; m_rx_data  in  LEN_DATA  MISO byte, valid with m_done.

Function
REQ-017 FSM states IDLE, LOAD, XFER, FIN; encoding fixed in shared header.
REQ-018 IDLE: if any req bit high, select winner round-robin starting at (last_owner+1) mod NUM_REQ; next cycle grant=winner one-hot, m_ss_hold=1, byte_cnt=0, len latched, -> LOAD.
REQ-019 IDLE with req all zero: stay, grant=0, all pulses 0.
REQ-020 LOAD (exactly 1 cycle): m_start=1, m_tx_data=owner slice of req_data, tx_pop[owner]=1, watchdog cleared, -> XFER.
REQ-021 XFER: on m_done, rx_data<=m_rx_data, rx_valid[owner]=1 next cycle; if byte_cnt==len -> FIN else byte_cnt+1, -> LOAD.
REQ-022 Byte-to-byte gap: m_done to next m_start is exactly 2 clk cycles.
REQ-023 XFER watchdog: counts cycles without m_done; at TIMEOUT, err[owner]=1 pulse, -> FIN without done pulse.
REQ-024 m_done in the same cycle as watchdog reaching TIMEOUT: m_done wins, no err.
REQ-025 FIN (1 cycle): done[owner]=1 unless aborted, m_ss_hold=0, last_owner<=owner, grant=0, -> IDLE.
REQ-026 req deassert by owner mid-burst ignored; burst runs to completion or timeout.
REQ-027 len latched at grant; req_len changes mid-burst have no effect.
REQ-028 m_done while in IDLE, LOAD or FIN ignored.
REQ-029 Owner holding req high after FIN competes again; others with pending req get priority (no starvation: any requester granted within NUM_REQ bursts).
REQ-030 byte_cnt width LEN_BURST, no wrap: maximum len = 2^LEN_BURST-1 gives 2^LEN_BURST bytes.

Reset
REQ-031 rst_n low on posedge clk: state IDLE, grant=0, tx_pop=0, rx_valid=0, done=0, err=0, m_start=0, m_ss_hold=0, m_tx_data=0, rx_data=0, byte_cnt=0, watchdog=0, last_owner=NUM_REQ-1 (requester 0 first).
REQ-032 Reset mid-burst aborts immediately; no done/err pulse emitted; m_ss_hold drops in the same cycle.

Structure
REQ-033 Header spi_defs.vh holds LEN_DATA default, FSM state codes, TIMEOUT default; shared with the SPI master.
REQ-034 One sub-module spi_rr_pick: combinational round-robin select (req, last_owner -> one-hot winner, any).
REQ-035 All outputs registered; no combinational path from m_done to m_start.

Verification
REQ-036 Single: req=01, len0=0, data0=A5, m_done 10 cycles after m_start with rx 3C -> one m_start, tx_pop[0], rx_valid[0] rx_data=3C, done[0], m_ss_hold high start to FIN.
REQ-037 Burst: len0=2 -> exactly 3 m_start, 3 tx_pop[0], 3 rx_valid[0], m_ss_hold never drops between bytes, one done[0].
REQ-038 Contention: req=11 held continuously, len=0 -> grants alternate 0,1,0,1 starting at 0 after reset.
REQ-039 Timeout: TIMEOUT=16, m_done never returned -> err[0] at cycle 16 of XFER, no done, back to IDLE, next request serviced.
REQ-040 Reset mid-burst: rst_n low during XFER of byte 2 -> all outputs 0 next cycle, following req=10 granted to requester 1 normally.
REQ-041 Spurious m_done in IDLE and req0 drop mid-burst -> no pulses in IDLE; burst still completes with done[0].
